// File: rtl/decode_writeback.sv
// ---------------------------------------------------------------------------
// decode_writeback
//   Decode and writeback stage of a sequential Y86-64 processor. It picks the
//   source and destination register IDs from the fetched instruction, reads
//   the 15-entry register file combinationally, and commits valE/valM on a
//   rising clock edge when wb_en is high.
//
// Ports
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   wb_en           : commit strobe for the register writes
//   icode, rA, rB   : instruction code and register specifiers from fetch
//   cnd             : condition flag from execute (gates cmovXX writes)
//   valE, valM      : ALU result and memory read data to commit
//   srcA, srcB      : decoded source register IDs
//   dstE, dstM      : decoded destination register IDs
//   valA, valB      : R[srcA], R[srcB]; 0 when the ID is F (RNONE)
//   dbg_sel,dbg_val : debug read port; dbg_val is 0 when dbg_sel is F
//
// There is no valid/ready handshake here. Inputs are sampled on every rising
// clk edge where wb_en=1, and the read outputs are purely combinational.
// ---------------------------------------------------------------------------
module decode_writeback #(
  parameter logic [63:0] RSP_INIT = 64'd0,
  parameter int          NREG     = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_en,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic [63:0] valA,
  output logic [63:0] valB,
  input  logic [3:0]  dbg_sel,
  output logic [63:0] dbg_val
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  logic [63:0] regs [NREG];

  // ID selection. Every path not listed falls to RNONE, which also covers
  // icodes C..F and any unknown icode, so such instructions never write.
  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (icode)
      I_CMOV: begin
        srcA = rA;
        dstE = cnd ? rB : RNONE;
      end
      I_IRMOVQ: begin
        dstE = rB;
      end
      I_RMMOVQ: begin
        srcA = rA;
        srcB = rB;
      end
      I_MRMOVQ: begin
        srcB = rB;
        dstM = rA;
      end
      I_OPQ: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      I_CALL: begin
        srcB = RRSP;
        dstE = RRSP;
      end
      I_RET: begin
        srcA = RRSP;
        srcB = RRSP;
        dstE = RRSP;
      end
      I_PUSHQ: begin
        srcA = rA;
        srcB = RRSP;
        dstE = RRSP;
      end
      I_POPQ: begin
        srcA = RRSP;
        srcB = RRSP;
        dstE = RRSP;
        dstM = rA;
      end
      default: begin
      end
    endcase
  end

  // Reads see the pre-edge state; RNONE reads as zero.
  assign valA    = (srcA    == RNONE) ? 64'd0 : regs[srcA];
  assign valB    = (srcB    == RNONE) ? 64'd0 : regs[srcB];
  assign dbg_val = (dbg_sel == RNONE) ? 64'd0 : regs[dbg_sel];

  // Writes. The M port is checked first so that popq %rsp (dstE == dstM)
  // keeps the popped value and drops the incremented stack pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (i == 4) ? RSP_INIT : 64'd0;
      end
    end else if (wb_en) begin
      for (int i = 0; i < NREG; i++) begin
        if (dstM != RNONE && dstM == 4'(i)) begin
          regs[i] <= valM;
        end else if (dstE != RNONE && dstE == 4'(i)) begin
          regs[i] <= valE;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_writeback.sv
// ---------------------------------------------------------------------------
// tb_decode_writeback
//   Directed bench for decode_writeback with RSP_INIT = 64'h100. Expected
//   values are hand-computed; a small register model tracks the intended
//   architectural state so whole-file sweeps can be compared.
// ---------------------------------------------------------------------------
module tb_decode_writeback;

  localparam logic [63:0] RSP_INIT = 64'h100;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        wb_en;
  logic [3:0]  icode, rA, rB;
  logic        cnd;
  logic [63:0] valE, valM;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB;
  logic [3:0]  dbg_sel;
  logic [63:0] dbg_val;

  decode_writeback #(.RSP_INIT(RSP_INIT), .NREG(15)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_en   (wb_en),
    .icode   (icode),
    .rA      (rA),
    .rB      (rB),
    .cnd     (cnd),
    .valE    (valE),
    .valM    (valM),
    .srcA    (srcA),
    .srcB    (srcB),
    .dstE    (dstE),
    .dstM    (dstM),
    .valA    (valA),
    .valB    (valB),
    .dbg_sel (dbg_sel),
    .dbg_val (dbg_val)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [63:0] model [15];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ids(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                           input logic [3:0] ee, input logic [3:0] em);
    check({tag, ".srcA"}, {60'd0, srcA}, {60'd0, ea});
    check({tag, ".srcB"}, {60'd0, srcB}, {60'd0, eb});
    check({tag, ".dstE"}, {60'd0, dstE}, {60'd0, ee});
    check({tag, ".dstM"}, {60'd0, dstM}, {60'd0, em});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) model[i] = (i == 4) ? RSP_INIT : 64'd0;
  endtask

  // Sweep the whole register file through the debug port.
  task automatic check_all(input string tag);
    for (int i = 0; i < 15; i++) begin
      dbg_sel = 4'(i);
      #1;
      check($sformatf("%s.R%0d", tag, i), dbg_val, model[i]);
    end
  endtask

  task automatic peek(input string tag, input logic [3:0] id, input logic [63:0] exp);
    dbg_sel = id;
    #1;
    check(tag, dbg_val, exp);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [63:0] e, input logic [63:0] m,
                       input logic en);
    icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m; wb_en = en;
    #1;
  endtask

  // One rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    dbg_sel = 4'h0;
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);
    model_reset();

    // Reset values visible while reset is still asserted.
    repeat (2) @(posedge clk);
    #1;
    peek("in_reset.R4", 4'h4, 64'h100);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("post_reset");
    peek("dbg_rnone", 4'hF, 64'd0);

    // pushq decode with rA = 0: srcB is %rsp and reads the reset value.
    drive(4'hA, 4'h0, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);
    check_ids("pushq", 4'h0, 4'h4, 4'h4, 4'hF);
    check("pushq.valB", valB, 64'h100);

    // irmovq into R2; valA/valB must not bypass before the edge.
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'hDEAD_BEEF, 64'd0, 1'b1);
    check_ids("irmovq", 4'hF, 4'hF, 4'h2, 4'hF);
    check("irmovq.valA", valA, 64'd0);
    peek("irmovq.pre_edge", 4'h2, 64'd0);
    tick();
    model[2] = 64'hDEAD_BEEF;
    wb_en = 1'b0;
    peek("irmovq.R2", 4'h2, 64'hDEAD_BEEF);

    drive(4'h6, 4'h2, 4'h2, 1'b0, 64'd0, 64'd0, 1'b0);
    check_ids("opq", 4'h2, 4'h2, 4'h2, 4'hF);
    check("opq.valA", valA, 64'hDEAD_BEEF);
    check("opq.valB", valB, 64'hDEAD_BEEF);

    // cmov not taken, then taken.
    drive(4'h2, 4'h1, 4'h3, 1'b0, 64'd5, 64'd0, 1'b1);
    check_ids("cmov_nt", 4'h1, 4'hF, 4'hF, 4'hF);
    tick();
    peek("cmov_nt.R3", 4'h3, 64'd0);
    drive(4'h2, 4'h1, 4'h3, 1'b1, 64'd5, 64'd0, 1'b1);
    check("cmov_t.dstE", {60'd0, dstE}, 64'h3);
    tick();
    model[3] = 64'd5;
    peek("cmov_t.R3", 4'h3, 64'd5);

    // popq %rsp: M wins the collision.
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'h55, 1'b1);
    check_ids("popq_rsp", 4'h4, 4'h4, 4'h4, 4'h4);
    check("popq_rsp.valA", valA, 64'h100);
    tick();
    model[4] = 64'h55;
    peek("popq_rsp.R4", 4'h4, 64'h55);

    // popq %rcx: both ports write different registers.
    drive(4'hB, 4'h1, 4'hF, 1'b0, 64'h108, 64'h77, 1'b1);
    check_ids("popq_r1", 4'h4, 4'h4, 4'h4, 4'h1);
    tick();
    model[1] = 64'h77;
    model[4] = 64'h108;
    wb_en = 1'b0;
    check_all("popq_r1");

    // wb_en low holds state even with a valid destination.
    drive(4'h3, 4'hF, 4'h5, 1'b0, 64'hAA, 64'd0, 1'b0);
    tick();
    peek("hold.R5", 4'h5, 64'd0);

    // mrmovq: srcB = rB, dstM = rA.
    drive(4'h5, 4'h6, 4'h2, 1'b0, 64'h1234, 64'hCAFE, 1'b1);
    check_ids("mrmovq", 4'hF, 4'h2, 4'hF, 4'h6);
    check("mrmovq.valB", valB, 64'hDEAD_BEEF);
    tick();
    model[6] = 64'hCAFE;
    peek("mrmovq.R6", 4'h6, 64'hCAFE);

    // call / ret / rmmovq / halt decode.
    drive(4'h8, 4'h1, 4'h2, 1'b0, 64'd0, 64'd0, 1'b0);
    check_ids("call", 4'hF, 4'h4, 4'h4, 4'hF);
    drive(4'h9, 4'h1, 4'h2, 1'b0, 64'd0, 64'd0, 1'b0);
    check_ids("ret", 4'h4, 4'h4, 4'h4, 4'hF);
    drive(4'h4, 4'h1, 4'h3, 1'b0, 64'd0, 64'd0, 1'b0);
    check_ids("rmmovq", 4'h1, 4'h3, 4'hF, 4'hF);
    check("rmmovq.valA", valA, 64'h77);
    check("rmmovq.valB", valB, 64'd5);
    drive(4'h0, 4'h1, 4'h3, 1'b0, 64'd0, 64'd0, 1'b0);
    check_ids("halt", 4'hF, 4'hF, 4'hF, 4'hF);

    // Async reset mid-cycle after writing R7 = 9.
    drive(4'h3, 4'hF, 4'h7, 1'b0, 64'd9, 64'd0, 1'b1);
    tick();
    peek("r7_written", 4'h7, 64'd9);
    #1;
    rst_n = 1'b0;
    peek("async.R7", 4'h7, 64'd0);
    peek("async.R4", 4'h4, 64'h100);
    tick();
    peek("reset_edge.R7", 4'h7, 64'd0);
    model_reset();
    wb_en = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    check_all("after_async");

    // Illegal icode and RNONE operand: nothing is written.
    drive(4'hD, 4'h1, 4'h2, 1'b1, 64'h11, 64'h22, 1'b1);
    check_ids("icode_D", 4'hF, 4'hF, 4'hF, 4'hF);
    check("icode_D.valA", valA, 64'd0);
    check("icode_D.valB", valB, 64'd0);
    tick();
    drive(4'h3, 4'h1, 4'hF, 1'b0, 64'h33, 64'h44, 1'b1);
    check("irmovq_rnone.dstE", {60'd0, dstE}, 64'hF);
    tick();
    wb_en = 1'b0;
    check_all("illegal");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
